metro_call_dispatch: RTL and testbench

// Passenger-side initiator for the metro track controller. Debounces the six

---
 rtl/metro_call_dispatch.sv | 191 +++++++++++++++++++
 tb/tb_metro_call_dispatch.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/metro_call_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : metro_call_dispatch
// Brief    : Debounced station calls, SCAN target selection, valid/ack request
//            issue and arrival supervision for the metro track controller.
// Revision : 1.0
// ============================================================================
module metro_call_dispatch #(
    parameter int unsigned N_ST       = 6,
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter logic [31:0] TMO_CYCLES = 32'd3000000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_ST-1:0] call_btn,
    input  logic [N_ST-1:0] at_station,
    input  logic            req_ack,
    output logic            req_valid,
    output logic [2:0]      req_station,
    output logic            req_dir,
    output logic [N_ST-1:0] pending,
    output logic            busy,
    output logic            err_multi,
    output logic            err_timeout
);

    localparam int unsigned          C_DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [C_DEB_W-1:0]   C_DEB_LAST = C_DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_REQ    = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    state_t            r_state;
    logic [N_ST-1:0]   r_sync1;
    logic [N_ST-1:0]   r_sync2;
    logic [2:0]        r_last_pos;
    logic [31:0]       r_tmo_cnt;

    logic [N_ST-1:0]   w_set;
    logic [N_ST-1:0]   w_clr;
    logic [3:0]        w_pop;
    logic              w_one;
    logic              w_multi;
    logic [2:0]        w_at_idx;
    logic              w_up_found;
    logic [2:0]        w_up_idx;
    logic              w_dn_found;
    logic [2:0]        w_dn_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= call_btn;
            r_sync2 <= r_sync1;
        end
    end

    // The set pulse fires in the same cycle the debounced level goes high.
    genvar gi;
    generate
        for (gi = 0; gi < N_ST; gi++) begin : g_deb
            logic [C_DEB_W-1:0] r_cnt;
            logic               r_lvl;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                    r_lvl <= 1'b0;
                end else if (r_sync2[gi] == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == C_DEB_LAST) begin
                    r_cnt <= '0;
                    r_lvl <= r_sync2[gi];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_set[gi] = r_sync2[gi] & ~r_lvl & (r_cnt == C_DEB_LAST);
        end
    endgenerate

    assign w_pop   = 4'($countones(at_station));
    assign w_one   = (w_pop == 4'd1);
    assign w_multi = (w_pop > 4'd1);
    assign w_clr   = w_multi ? '0 : at_station;

    always_comb begin
        w_at_idx   = '0;
        w_up_found = 1'b0;
        w_up_idx   = '0;
        w_dn_found = 1'b0;
        w_dn_idx   = '0;
        for (int i = 0; i < int'(N_ST); i++) begin
            if (at_station[i]) w_at_idx = 3'(i);
            if (pending[i] && (3'(i) < r_last_pos)) begin
                w_dn_found = 1'b1;
                w_dn_idx   = 3'(i);
            end
        end
        // Walk downward so the last hit is the lowest index above last_pos.
        for (int i = int'(N_ST) - 1; i >= 0; i--) begin
            if (pending[i] && (3'(i) > r_last_pos)) begin
                w_up_found = 1'b1;
                w_up_idx   = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            req_valid   <= 1'b0;
            req_station <= '0;
            req_dir     <= 1'b0;
            pending     <= '0;
            busy        <= 1'b0;
            err_multi   <= 1'b0;
            err_timeout <= 1'b0;
            r_last_pos  <= '0;
            r_tmo_cnt   <= '0;
        end else begin
            pending <= (pending | w_set) & ~w_clr;
            if (w_one)   r_last_pos <= w_at_idx;
            if (w_multi) err_multi  <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if ((pending & ~at_station) != '0) begin
                        r_state <= S_SELECT;
                        busy    <= 1'b1;
                    end
                end
                S_SELECT: begin
                    if (pending == '0) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_state   <= S_REQ;
                        req_valid <= 1'b1;
                        if (!req_dir && w_up_found) begin
                            req_station <= w_up_idx;
                        end else if (req_dir && w_dn_found) begin
                            req_station <= w_dn_idx;
                        end else if (!req_dir && w_dn_found) begin
                            req_dir     <= 1'b1;
                            req_station <= w_dn_idx;
                        end else if (req_dir && w_up_found) begin
                            req_dir     <= 1'b0;
                            req_station <= w_up_idx;
                        end else begin
                            // Only the last docked station is pending (train moved off it).
                            req_station <= r_last_pos;
                        end
                    end
                end
                S_REQ: begin
                    if (req_ack) begin
                        r_state   <= S_WAIT;
                        req_valid <= 1'b0;
                        r_tmo_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (at_station[req_station]) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (r_tmo_cnt >= (TMO_CYCLES - 32'd1)) begin
                        r_state     <= S_IDLE;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                    end else if (r_tmo_cnt != 32'hFFFF_FFFF) begin
                        r_tmo_cnt <= r_tmo_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_metro_call_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_metro_call_dispatch
// Brief    : Scenario tasks plus randomized SCAN rounds against a set-based model.
// Revision : 1.0
// ============================================================================
module tb_metro_call_dispatch;

    localparam int unsigned N_ST = 6;
    localparam int unsigned DEB  = 4;
    localparam logic [31:0] TMO  = 32'd50;

    logic            clk        = 1'b0;
    logic            rst_n      = 1'b1;
    logic [N_ST-1:0] call_btn   = '0;
    logic [N_ST-1:0] at_station = '0;
    logic            req_ack    = 1'b0;
    logic            req_valid;
    logic [2:0]      req_station;
    logic            req_dir;
    logic [N_ST-1:0] pending;
    logic            busy;
    logic            err_multi;
    logic            err_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    metro_call_dispatch #(
        .N_ST       (N_ST),
        .DEB_CYCLES (DEB),
        .TMO_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .call_btn    (call_btn),
        .at_station  (at_station),
        .req_ack     (req_ack),
        .req_valid   (req_valid),
        .req_station (req_station),
        .req_dir     (req_dir),
        .pending     (pending),
        .busy        (busy),
        .err_multi   (err_multi),
        .err_timeout (err_timeout)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        call_btn   = '0;
        at_station = '0;
        req_ack    = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic wait_valid(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (req_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_wait_valid: req_valid=%b, want 1 within 40 cycles", name, req_valid);
        end
    endtask

    // SCAN rule: nearest pending beyond last_pos in the current direction, else reverse.
    function automatic void scan_pick(input logic [N_ST-1:0] p, input int lp, input bit dir,
                                      output int st, output bit nd);
        int up = -1;
        int dn = -1;
        for (int i = 0; i < int'(N_ST); i++) begin
            if (p[i] && i > lp && up < 0) up = i;
            if (p[i] && i < lp) dn = i;
        end
        if (!dir) begin
            if (up >= 0) begin st = up; nd = 1'b0; end
            else         begin st = dn; nd = 1'b1; end
        end else begin
            if (dn >= 0) begin st = dn; nd = 1'b1; end
            else         begin st = up; nd = 1'b0; end
        end
    endfunction

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (req_valid !== 1'b0)   begin errors++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
        checks++; if (req_station !== 3'd0) begin errors++; $display("FAIL reset_req_station: got %0d want 0", req_station); end
        checks++; if (req_dir !== 1'b0)     begin errors++; $display("FAIL reset_req_dir: got %b want 0", req_dir); end
        checks++; if (pending !== 6'b0)     begin errors++; $display("FAIL reset_pending: got %b want 000000", pending); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({err_multi, err_timeout} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", {err_multi, err_timeout}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_bounce;
        bit ok;
        bit leaked = 1'b0;
        do_reset;
        for (int i = 0; i < 10; i++) begin
            call_btn[3] = (i % 2 == 0);
            tick(2);
            if (pending !== 6'b0) leaked = 1'b1;
        end
        checks++; if (leaked) begin errors++; $display("FAIL bounce_no_accept: pending changed during bounce, want 000000"); end
        call_btn[3] = 1'b1;
        tick(10);
        checks++; if (pending !== 6'b001000) begin errors++; $display("FAIL bounce_pending: got %b want 001000", pending); end
        wait_valid("bounce", ok);
        call_btn = '0;
        checks++; if (req_station !== 3'd3) begin errors++; $display("FAIL bounce_station: got %0d want 3", req_station); end
    endtask

    task automatic test_scan_up;
        bit ok;
        do_reset;
        at_station = 6'b000010;
        tick(1);
        at_station = '0;
        call_btn = 6'b100001;
        wait_valid("scan_up", ok);
        call_btn = '0;
        checks++; if (req_station !== 3'd5) begin errors++; $display("FAIL scan_up_station: got %0d want 5", req_station); end
        checks++; if (req_dir !== 1'b0)     begin errors++; $display("FAIL scan_up_dir: got %b want 0", req_dir); end
        checks++; if (pending !== 6'b100001) begin errors++; $display("FAIL scan_up_pending: got %b want 100001", pending); end
        req_ack = 1'b1; tick(1); req_ack = 1'b0;
        tick(2);
        at_station = 6'b100000;
        tick(1);
        at_station = '0;
        checks++; if (pending !== 6'b000001) begin errors++; $display("FAIL scan_up_served: got %b want 000001", pending); end
        wait_valid("scan_rev", ok);
        checks++; if (req_station !== 3'd0) begin errors++; $display("FAIL scan_rev_station: got %0d want 0", req_station); end
        checks++; if (req_dir !== 1'b1)     begin errors++; $display("FAIL scan_rev_dir: got %b want 1", req_dir); end
        req_ack = 1'b1; tick(1); req_ack = 1'b0;
        at_station = 6'b000001;
        tick(1);
        at_station = '0;
        checks++; if (pending !== 6'b0) begin errors++; $display("FAIL scan_rev_served: got %b want 000000", pending); end
    endtask

    task automatic test_handshake;
        bit ok;
        do_reset;
        call_btn = 6'b010000;
        wait_valid("hs", ok);
        checks++; if (req_station !== 3'd4) begin errors++; $display("FAIL hs_station: got %0d want 4", req_station); end
        call_btn = 6'b000010;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++;
            if (req_valid !== 1'b1 || req_station !== 3'd4) begin
                errors++;
                $display("FAIL hs_hold[%0d]: valid=%b station=%0d want valid=1 station=4", i, req_valid, req_station);
            end
        end
        call_btn = '0;
        req_ack = 1'b1; tick(1); req_ack = 1'b0;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL hs_drop: req_valid=%b want 0", req_valid); end
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hs_busy[%0d]: got %b want 1", i, busy); end
        end
        at_station = 6'b010000;
        tick(1);
        at_station = '0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hs_idle: busy=%b want 0", busy); end
        checks++; if (pending !== 6'b000010) begin errors++; $display("FAIL hs_pending: got %b want 000010", pending); end
        wait_valid("hs_next", ok);
        checks++; if (req_station !== 3'd1 || req_dir !== 1'b1) begin
            errors++; $display("FAIL hs_next: station=%0d dir=%b want 1/1", req_station, req_dir);
        end
    endtask

    task automatic test_docked_press;
        do_reset;
        at_station = 6'b000100;
        tick(1);
        call_btn = 6'b000100;
        tick(10);
        checks++; if (pending !== 6'b0) begin errors++; $display("FAIL docked_pending: got %b want 000000", pending); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL docked_busy: got %b want 0", busy); end
        call_btn = '0;
        tick(DEB + 4);
        at_station = '0;
        tick(3);
        checks++; if (pending !== 6'b0 || req_valid !== 1'b0) begin
            errors++; $display("FAIL docked_after: pending=%b valid=%b want 000000/0", pending, req_valid);
        end
    endtask

    task automatic test_faults;
        bit ok;
        bit seen = 1'b0;
        do_reset;
        at_station = 6'b000010;
        tick(1);
        at_station = 6'b000110;
        tick(1);
        at_station = '0;
        checks++; if (err_multi !== 1'b1) begin errors++; $display("FAIL multi_flag: got %b want 1", err_multi); end
        call_btn = 6'b000101;
        wait_valid("multi", ok);
        call_btn = '0;
        checks++; if (req_station !== 3'd2 || req_dir !== 1'b0) begin
            errors++; $display("FAIL multi_lastpos: station=%0d dir=%b want 2/0", req_station, req_dir);
        end
        req_ack = 1'b1; tick(1); req_ack = 1'b0;
        tick(40);
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b want 0", err_timeout); end
        for (int i = 0; i < 20; i++) begin
            if (err_timeout === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        checks++; if (!seen) begin errors++; $display("FAIL tmo_flag: err_timeout=%b want 1", err_timeout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle: busy=%b want 0", busy); end
        checks++; if (pending !== 6'b000101) begin errors++; $display("FAIL tmo_pending: got %b want 000101", pending); end
        checks++; if (err_multi !== 1'b1) begin errors++; $display("FAIL multi_sticky: got %b want 1", err_multi); end
    endtask

    task automatic test_random_scan;
        logic [N_ST-1:0] m_pend;
        logic [N_ST-1:0] mask;
        logic [N_ST-1:0] bitv;
        int  m_lp;
        bit  m_dir;
        int  exp_st;
        bit  exp_dir;
        int  s;
        bit  ok;
        do_reset;
        m_lp  = 0;
        m_dir = 1'b0;
        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                s = int'($urandom_range(0, N_ST - 1));
                at_station = 6'(1 << s);
                tick(1);
                at_station = '0;
                m_lp = s;
                tick(1);
            end
            mask = 6'($urandom_range(1, 63)) & ~6'(1 << m_lp);
            if (mask == '0) mask = (m_lp == 0) ? 6'b000010 : 6'b000001;
            call_btn = mask;
            m_pend   = mask;
            while (m_pend != '0) begin
                wait_valid("rand", ok);
                if (!ok) break;
                call_btn = '0;
                scan_pick(m_pend, m_lp, m_dir, exp_st, exp_dir);
                checks++; if (req_station !== 3'(exp_st)) begin errors++; $display("FAIL rand_station: got %0d want %0d (pend %b lp %0d)", req_station, exp_st, m_pend, m_lp); end
                checks++; if (req_dir !== exp_dir) begin errors++; $display("FAIL rand_dir: got %b want %b", req_dir, exp_dir); end
                checks++; if (pending !== m_pend) begin errors++; $display("FAIL rand_pending: got %b want %b", pending, m_pend); end
                repeat ($urandom_range(0, 3)) begin
                    tick(1);
                    checks++;
                    if (req_valid !== 1'b1 || req_station !== 3'(exp_st)) begin
                        errors++; $display("FAIL rand_hold: valid=%b station=%0d want 1/%0d", req_valid, req_station, exp_st);
                    end
                end
                req_ack = 1'b1; tick(1); req_ack = 1'b0;
                checks++; if (req_valid !== 1'b0 || busy !== 1'b1) begin
                    errors++; $display("FAIL rand_ack: valid=%b busy=%b want 0/1", req_valid, busy);
                end
                tick(int'($urandom_range(0, 8)));
                bitv = 6'(1 << exp_st);
                at_station = bitv;
                tick(1);
                at_station = '0;
                m_pend = m_pend & ~bitv;
                m_lp   = exp_st;
                m_dir  = exp_dir;
                checks++; if (pending !== m_pend) begin errors++; $display("FAIL rand_served: got %b want %b", pending, m_pend); end
            end
            call_btn = '0;
            tick(DEB + 6);
        end
    endtask

    task automatic test_reset_mid_req;
        bit ok;
        do_reset;
        call_btn = 6'b100000;
        wait_valid("rst_mid", ok);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", req_valid); end
        checks++; if (pending !== 6'b0)   begin errors++; $display("FAIL rst_mid_pending: got %b want 000000", pending); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        call_btn = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        test_reset;
        test_bounce;
        test_scan_up;
        test_handshake;
        test_docked_press;
        test_faults;
        test_random_scan;
        test_reset_mid_req;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
